// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transfer sequencer: CS framing, byte issue/collect handshakes
// and the prescaled SPI clock with its high/low edge pulses for one frontend.
`timescale 1ns/1ps
module spi_xfer_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DLY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic [DIV_W-1:0] cfg_clk_div_i,
  input  logic [DLY_W-1:0] cfg_cs_setup_i,
  input  logic [DLY_W-1:0] cfg_cs_hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             fe_cs_o,
  output logic             fe_prescaled_clk_o,
  output logic             fe_high_pulse_o,
  output logic             fe_low_pulse_o,
  output logic             fe_transmit_o,
  output logic [7:0]       fe_transmit_data_o,
  input  logic [7:0]       fe_received_data_i,
  input  logic             fe_transmit_done_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_ISSUE, S_BUSY, S_CS_HOLD
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [DIV_W-1:0] div_q, pcnt_q;
  logic [DLY_W-1:0] setup_q, hold_q, dly_q;
  logic             abort_pend_q;
  logic             cs_q, sclk_q, hp_q, lp_q, done_q, aborted_q, rx_valid_q;
  logic [7:0]       rx_data_q;

  logic [DLY_W-1:0] dly_lim;
  logic [DLY_W-1:0] dly_inc;
  logic             dly_last;

  // Both framing delays share one counter; a zero setting still costs one cycle.
  assign dly_lim  = (state_q == S_CS_HOLD) ? hold_q : setup_q;
  assign dly_last = ({1'b0, dly_q} + (DLY_W+1)'(1)) >= {1'b0, dly_lim};
  assign dly_inc  = (dly_q == '1) ? dly_q : dly_q + DLY_W'(1);

  // A byte may launch only if the RX slot is free by the time it completes.
  assign tx_ready_o = (state_q == S_ISSUE) && (rem_q != '0) && !abort_i &&
                      (!rx_valid_q || rx_ready_i);
  assign fe_transmit_o      = tx_ready_o && tx_valid_i;
  assign fe_transmit_data_o = tx_ready_o ? tx_data_i : 8'h00;

  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = done_q;
  assign aborted_o          = aborted_q;
  assign rx_data_o          = rx_data_q;
  assign rx_valid_o         = rx_valid_q;
  assign fe_cs_o            = cs_q;
  assign fe_prescaled_clk_o = sclk_q;
  assign fe_high_pulse_o    = hp_q;
  assign fe_low_pulse_o     = lp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      div_q        <= '0;
      pcnt_q       <= '0;
      setup_q      <= '0;
      hold_q       <= '0;
      dly_q        <= '0;
      abort_pend_q <= 1'b0;
      cs_q         <= 1'b0;
      sclk_q       <= 1'b0;
      hp_q         <= 1'b0;
      lp_q         <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      hp_q      <= 1'b0;
      lp_q      <= 1'b0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      // Prescaler free-runs for the whole framed transfer, independent of bytes.
      if (state_q != S_IDLE) begin
        if (pcnt_q == div_q) begin
          pcnt_q <= '0;
          sclk_q <= ~sclk_q;
          hp_q   <= ~sclk_q;
          lp_q   <= sclk_q;
        end else begin
          pcnt_q <= pcnt_q + DIV_W'(1);
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_CS_SETUP;
            cs_q         <= 1'b1;
            rem_q        <= len_i;
            div_q        <= cfg_clk_div_i;
            setup_q      <= cfg_cs_setup_i;
            hold_q       <= cfg_cs_hold_i;
            dly_q        <= '0;
            pcnt_q       <= '0;
            sclk_q       <= 1'b0;
            abort_pend_q <= 1'b0;
          end
        end
        S_CS_SETUP: begin
          if (abort_i) begin
            state_q      <= S_CS_HOLD;
            abort_pend_q <= 1'b1;
            dly_q        <= '0;
          end else if (dly_last) begin
            state_q <= S_ISSUE;
            dly_q   <= '0;
          end else begin
            dly_q <= dly_inc;
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            state_q      <= S_CS_HOLD;
            abort_pend_q <= 1'b1;
            dly_q        <= '0;
          end else if (rem_q == '0) begin
            state_q <= S_CS_HOLD;
            dly_q   <= '0;
          end else if (fe_transmit_o) begin
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // An abort here only takes effect once the byte in flight is delivered.
          if (abort_i) abort_pend_q <= 1'b1;
          if (fe_transmit_done_i) begin
            rx_data_q  <= fe_received_data_i;
            rx_valid_q <= 1'b1;
            if (abort_pend_q || abort_i) begin
              state_q <= S_CS_HOLD;
              dly_q   <= '0;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_CS_HOLD: begin
          if (dly_last) begin
            state_q   <= S_IDLE;
            cs_q      <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort_pend_q;
            dly_q     <= '0;
          end else begin
            dly_q <= dly_inc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomised and directed bench for spi_xfer_ctrl with a loopback frontend and
// a timeline-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned DLY_W = 8;
  localparam int PH_IDLE = 0, PH_SETUP = 1, PH_ISSUE = 2, PH_BYTE = 3, PH_HOLD = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0, abort_i = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic [DIV_W-1:0] cfg_clk_div_i = '0;
  logic [DLY_W-1:0] cfg_cs_setup_i = '0, cfg_cs_hold_i = '0;
  logic busy_o, done_o, aborted_o;
  logic [7:0] tx_data_i = 8'h00;
  logic tx_valid_i = 1'b0, tx_ready_o;
  logic [7:0] rx_data_o;
  logic rx_valid_o, rx_ready_i = 1'b0;
  logic fe_cs_o, fe_prescaled_clk_o, fe_high_pulse_o, fe_low_pulse_o, fe_transmit_o;
  logic [7:0] fe_transmit_data_o;
  logic [7:0] fe_received_data_i = 8'h00;
  logic fe_transmit_done_i = 1'b0;

  spi_xfer_ctrl #(.LEN_W(LEN_W), .DIV_W(DIV_W), .DLY_W(DLY_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .cfg_clk_div_i(cfg_clk_div_i), .cfg_cs_setup_i(cfg_cs_setup_i),
    .cfg_cs_hold_i(cfg_cs_hold_i), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .fe_cs_o(fe_cs_o), .fe_prescaled_clk_o(fe_prescaled_clk_o),
    .fe_high_pulse_o(fe_high_pulse_o), .fe_low_pulse_o(fe_low_pulse_o),
    .fe_transmit_o(fe_transmit_o), .fe_transmit_data_o(fe_transmit_data_o),
    .fe_received_data_i(fe_received_data_i), .fe_transmit_done_i(fe_transmit_done_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- stimulus knobs and logs ----------------
  logic [7:0] txq[$], sentlog[$], rxlog[$];
  int  valid_pct = 100, ready_pct = 100, abort_pct = 0;
  bit  tx_gate = 0, hs_seen = 0, last_abt = 0;
  int  done_cnt = 0, xmit_cnt = 0, cs_cnt = 0;

  // Source/sink driver: inputs change 1ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (hs_seen) begin
        hs_seen = 0;
        if (txq.size() > 0) void'(txq.pop_front());
      end
      tx_valid_i = !tx_gate && (txq.size() > 0) && (int'($urandom_range(99)) < valid_pct);
      tx_data_i  = (txq.size() > 0) ? txq[0] : 8'h00;
      rx_ready_i = int'($urandom_range(99)) < ready_pct;
      if (abort_pct > 0) abort_i = int'($urandom_range(999)) < abort_pct;
    end
  end

  // Loopback frontend: a byte completes after eight SPI rising-edge pulses.
  logic [7:0] fe_byte = 8'h00;
  bit fe_active = 0;
  int fe_hp = 0;
  initial begin
    forever begin
      @(negedge clk_i);
      fe_transmit_done_i = 1'b0;
      if (rst_i) fe_active = 0;
      else if (fe_transmit_o) begin
        fe_active = 1; fe_byte = fe_transmit_data_o; fe_hp = 0;
      end else if (fe_active && fe_high_pulse_o) begin
        fe_hp++;
        if (fe_hp == 8) begin
          fe_received_data_i = fe_byte; fe_transmit_done_i = 1'b1; fe_active = 0;
        end
      end
    end
  end

  // Event monitor feeding the transaction scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) begin done_cnt++; last_abt = aborted_o; end
      if (fe_cs_o) cs_cnt++;
      if (fe_transmit_o) xmit_cnt++;
      if (tx_ready_o && tx_valid_i) begin hs_seen = 1; sentlog.push_back(tx_data_i); end
      if (rx_valid_o && rx_ready_i) rxlog.push_back(rx_data_o);
    end
  end

  // ---------------- reference model ----------------
  // Framing delays are deadlines on an absolute cycle count; the SPI clock is
  // derived arithmetically from how many cycles the transfer has been framed.
  int ph = PH_IDLE, m_cyc = 0, m_deadline = 0, m_rem = 0, m_div = 0, m_hold = 0, m_runs = 0;
  bit m_ran = 0, m_rxv = 0, m_rxv_pre = 0, m_abt = 0, m_done = 0, m_abt_o = 0;
  logic [7:0] m_rxd = 8'h00, m_inflight = 8'h00;

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph = PH_IDLE; m_runs = 0; m_ran = 0; m_rxv = 0; m_rxd = 8'h00;
      m_done = 0; m_abt_o = 0; m_div = 0; m_abt = 0; m_rem = 0;
    end else begin
      m_cyc++;
      m_done = 0; m_abt_o = 0;
      m_ran = (ph != PH_IDLE);
      if (m_ran) m_runs++;
      m_rxv_pre = m_rxv;
      if (m_rxv && rx_ready_i) m_rxv = 0;
      case (ph)
        PH_IDLE: if (start_i) begin
          ph = PH_SETUP; m_rem = int'(len_i); m_div = int'(cfg_clk_div_i);
          m_hold = int'(cfg_cs_hold_i); m_runs = 0; m_abt = 0;
          m_deadline = m_cyc + max1(int'(cfg_cs_setup_i));
        end
        PH_SETUP: begin
          if (abort_i) begin ph = PH_HOLD; m_abt = 1; m_deadline = m_cyc + max1(m_hold); end
          else if (m_cyc >= m_deadline) ph = PH_ISSUE;
        end
        PH_ISSUE: begin
          if (abort_i) begin ph = PH_HOLD; m_abt = 1; m_deadline = m_cyc + max1(m_hold); end
          else if (m_rem == 0) begin ph = PH_HOLD; m_deadline = m_cyc + max1(m_hold); end
          else if (tx_valid_i && (!m_rxv_pre || rx_ready_i)) begin
            m_rem--; m_inflight = tx_data_i; ph = PH_BYTE;
          end
        end
        PH_BYTE: begin
          if (abort_i) m_abt = 1;
          if (fe_transmit_done_i) begin
            m_rxv = 1; m_rxd = m_inflight;
            if (m_abt) begin ph = PH_HOLD; m_deadline = m_cyc + max1(m_hold); end
            else ph = PH_ISSUE;
          end
        end
        default: if (m_cyc >= m_deadline) begin
          ph = PH_IDLE; m_done = 1; m_abt_o = m_abt;
        end
      endcase
    end
  end

  // Per-cycle compare of every DUT output against the model.
  bit e_rdy, e_clk;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      e_rdy = (ph == PH_ISSUE) && (m_rem != 0) && !abort_i && (!m_rxv || rx_ready_i);
      e_clk = ((m_runs / (m_div + 1)) % 2) == 1;
      check("busy", 32'(busy_o), 32'(ph != PH_IDLE));
      check("cs", 32'(fe_cs_o), 32'(ph != PH_IDLE));
      check("done", 32'(done_o), 32'(m_done));
      check("aborted", 32'(aborted_o), 32'(m_abt_o));
      check("rx_valid", 32'(rx_valid_o), 32'(m_rxv));
      if (m_rxv) check("rx_data", 32'(rx_data_o), 32'(m_rxd));
      check("tx_ready", 32'(tx_ready_o), 32'(e_rdy));
      check("transmit", 32'(fe_transmit_o), 32'(e_rdy && tx_valid_i));
      if (e_rdy && tx_valid_i) check("tx_data", 32'(fe_transmit_data_o), 32'(tx_data_i));
      check("sclk", 32'(fe_prescaled_clk_o), 32'(e_clk));
      check("high_pulse", 32'(fe_high_pulse_o),
            32'(m_ran && (m_runs % (m_div + 1) == 0) && e_clk));
      check("low_pulse", 32'(fe_low_pulse_o),
            32'(m_ran && (m_runs % (m_div + 1) == 0) && !e_clk));
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic prep();
    txq.delete(); sentlog.delete(); rxlog.delete();
    done_cnt = 0; xmit_cnt = 0; cs_cnt = 0; last_abt = 0;
  endtask

  task automatic go(input int len, input int div, input int su, input int ho);
    start_i = 1'b1; len_i = LEN_W'(len); cfg_clk_div_i = DIV_W'(div);
    cfg_cs_setup_i = DLY_W'(su); cfg_cs_hold_i = DLY_W'(ho);
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic xfer(input int len, input int div, input int su, input int ho);
    prep();
    for (int i = 0; i < len; i++) txq.push_back(8'($urandom));
    go(len, div, su, ho);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin cyc(1); n++; end
    if (done_cnt == 0) check({nm, "_timeout"}, 32'(0), 32'(1));
    ready_pct = 100;
    cyc(4);
  endtask

  task automatic wait_xmit(input string nm, input int cnt, input int budget);
    int n = 0;
    while (xmit_cnt < cnt && n < budget) begin cyc(1); n++; end
    if (xmit_cnt < cnt) check({nm, "_timeout"}, 32'(xmit_cnt), 32'(cnt));
  endtask

  task automatic scoreboard(input string nm);
    check({nm, "_rx_count"}, 32'(rxlog.size()), 32'(sentlog.size()));
    for (int i = 0; i < rxlog.size() && i < sentlog.size(); i++)
      check({nm, "_rx_byte"}, 32'(rxlog[i]), 32'(sentlog[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cyc(2);
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_cs", 32'(fe_cs_o), 32'(0));
    check("rst_sclk", 32'(fe_prescaled_clk_o), 32'(0));
    check("rst_rx_valid", 32'(rx_valid_o), 32'(0));
    rst_i = 1'b0;
    cyc(2);

    // Three-byte loopback, plus a start that arrives mid-transfer and is ignored.
    prep();
    txq.push_back(8'hA5); txq.push_back(8'h3C); txq.push_back(8'hFF);
    go(3, 1, 2, 2);
    wait_xmit("t1_x1", 1, 200);
    start_i = 1'b1; len_i = LEN_W'(9); cyc(1); start_i = 1'b0;
    wait_done("t1", 2000);
    check("t1_rx_count", 32'(rxlog.size()), 32'(3));
    if (rxlog.size() == 3) begin
      check("t1_rx0", 32'(rxlog[0]), 32'(8'hA5));
      check("t1_rx1", 32'(rxlog[1]), 32'(8'h3C));
      check("t1_rx2", 32'(rxlog[2]), 32'(8'hFF));
    end
    check("t1_done_once", 32'(done_cnt), 32'(1));
    check("t1_aborted", 32'(last_abt), 32'(0));

    // TX source stalls 50 cycles before the second byte.
    xfer(2, 1, 1, 1);
    wait_xmit("t2_x1", 1, 200);
    tx_gate = 1; cyc(50);
    check("t2_stall_xmit", 32'(xmit_cnt), 32'(1));
    check("t2_stall_cs", 32'(fe_cs_o), 32'(1));
    tx_gate = 0;
    wait_done("t2", 2000);
    check("t2_rx_count", 32'(rxlog.size()), 32'(2));
    scoreboard("t2");

    // RX sink backpressure blocks the next launch.
    ready_pct = 0;
    xfer(4, 0, 1, 1);
    begin
      int n = 0;
      while (!rx_valid_o && n < 500) begin cyc(1); n++; end
    end
    cyc(40);
    check("t3_bp_xmit", 32'(xmit_cnt), 32'(1));
    check("t3_bp_ready", 32'(tx_ready_o), 32'(0));
    ready_pct = 100;
    wait_done("t3", 2000);
    check("t3_rx_count", 32'(rxlog.size()), 32'(4));
    scoreboard("t3");

    // Abort during byte 2 of 5.
    xfer(5, 1, 1, 2);
    wait_xmit("t4_x2", 2, 500);
    cyc(4);
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
    wait_done("t4", 2000);
    check("t4_xmit", 32'(xmit_cnt), 32'(2));
    check("t4_rx_count", 32'(rxlog.size()), 32'(2));
    check("t4_aborted", 32'(last_abt), 32'(1));
    scoreboard("t4");

    // Zero-length transfer: framing only.
    xfer(0, 2, 3, 4);
    wait_done("t5", 200);
    check("t5_cs_cycles", 32'(cs_cnt), 32'(8));
    check("t5_xmit", 32'(xmit_cnt), 32'(0));
    check("t5_done", 32'(done_cnt), 32'(1));

    // Asynchronous reset in the middle of a byte, then a fresh transfer.
    xfer(2, 1, 1, 1);
    wait_xmit("t6_x1", 1, 200);
    cyc(3);
    #2 rst_i = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy_o), 32'(0));
    check("t6_rst_cs", 32'(fe_cs_o), 32'(0));
    check("t6_rst_sclk", 32'(fe_prescaled_clk_o), 32'(0));
    check("t6_rst_rx_valid", 32'(rx_valid_o), 32'(0));
    cyc(2);
    rst_i = 1'b0;
    cyc(1);
    xfer(1, 0, 0, 0);
    wait_done("t6", 1000);
    check("t6_rx_count", 32'(rxlog.size()), 32'(1));
    scoreboard("t6");

    // Randomised transfers with random handshakes and occasional aborts.
    for (int t = 0; t < 30; t++) begin
      valid_pct = int'($urandom_range(100, 30));
      ready_pct = int'($urandom_range(100, 30));
      abort_pct = (t % 3 == 0) ? 3 : 0;
      xfer(int'($urandom_range(6)), int'($urandom_range(3)),
           int'($urandom_range(4)), int'($urandom_range(4)));
      wait_done("rnd", 6000);
      abort_pct = 0; abort_i = 1'b0;
      cyc(2);
      check("rnd_done_once", 32'(done_cnt), 32'(1));
      scoreboard("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
